pipe_addsub: RTL

- Parametrised, pipelined successor of the team's 8-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands, one chunk of WIDTH/STAGES bits per pipeline stage, passing the carry between stages through registers.
- Adds signed-overflow and zero flags and valid/ready handshakes on both sides, so it can sit between streaming datapath blocks (accumulators, ALU front-ends).
- Throughput is one operation per cycle; latency is STAGES cycles.

---
 rtl/pipe_addsub.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
// Pipelined WIDTH-bit adder/subtractor with valid/ready handshakes on both
// sides. Each pipeline stage adds one CHUNK = WIDTH/STAGES bit slice and passes
// its carry to the next stage through a register, so no carry path crosses a
// stage boundary. Throughput is one beat per cycle. A beat accepted at edge N
// is presented with out_valid after edge N+STAGES-1.
//
// Parameters:
//   WIDTH   operand/result width (>= 2)
//   STAGES  pipeline depth (1..WIDTH, must divide WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears every valid bit and data reg
//   in_valid   operand beat valid
//   in_ready   beat can be accepted this cycle (depends only on out_valid/out_ready)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0 = a + b + cin, 1 = a - b - cin
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum        result
//   cout       carry out; in subtract mode 1 means no borrow
//   ovf        signed two's-complement overflow
//   zero       sum == 0
// -----------------------------------------------------------------------------
module pipe_addsub #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned MSB   = WIDTH - 1;
  localparam int unsigned LAST  = STAGES - 1;

  // Per-stage registers. r_a/r_b keep the operands (b already inverted for
  // subtract) so later stages find their unprocessed slices and the MSBs
  // needed for overflow; r_s collects the completed low sum bits.
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  logic              r_ovf;
  logic              r_zero;

  logic              w_adv;
  logic [WIDTH-1:0]  w_a_in  [STAGES];
  logic [WIDTH-1:0]  w_b_in  [STAGES];
  logic [WIDTH-1:0]  w_s_in  [STAGES];
  logic [WIDTH-1:0]  w_s_nxt [STAGES];
  logic [CHUNK:0]    w_chunk [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_c_nxt;
  logic              w_ovf_nxt;
  logic              w_zero_nxt;

  // Whole pipeline moves together; it only stalls when a finished result is
  // waiting on downstream.
  assign w_adv    = !r_v[LAST] || out_ready;
  assign in_ready = w_adv;

  // Stage inputs: stage 0 takes the ports (subtract folded into ~b / ~cin),
  // later stages take the previous stage's registers.
  always_comb begin
    w_a_in[0] = a;
    w_b_in[0] = sub ? ~b : b;
    w_s_in[0] = '0;
    w_c_in    = '0;
    w_c_in[0] = sub ? ~cin : cin;
    for (int k = 1; k < STAGES; k++) begin
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_s_in[k] = r_s[k-1];
      w_c_in[k] = r_c[k-1];
    end
  end

  // Each stage adds its own CHUNK-bit slice plus the registered carry.
  always_comb begin
    w_c_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_chunk[k] = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                 + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, w_c_in[k]};
      w_s_nxt[k] = w_s_in[k];
      w_s_nxt[k][k*CHUNK +: CHUNK] = w_chunk[k][CHUNK-1:0];
      w_c_nxt[k] = w_chunk[k][CHUNK];
    end
  end

  // Flags are formed in the last stage from its inputs so the outputs can be
  // driven straight from registers.
  always_comb begin
    w_ovf_nxt  = (w_a_in[LAST][MSB] == w_b_in[LAST][MSB]) &&
                 (w_s_nxt[LAST][MSB] != w_a_in[LAST][MSB]);
    w_zero_nxt = (w_s_nxt[LAST] == '0);
  end

  // Pipeline registers: reset clears everything (zero flag reflects sum = 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
      r_c    <= '0;
      r_v    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
    end else if (w_adv) begin
      r_v[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        r_v[k] <= r_v[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_a_in[k];
        r_b[k] <= w_b_in[k];
        r_s[k] <= w_s_nxt[k];
      end
      r_c    <= w_c_nxt;
      r_ovf  <= w_ovf_nxt;
      r_zero <= w_zero_nxt;
    end
  end

  assign out_valid = r_v[LAST];
  assign sum       = r_s[LAST];
  assign cout      = r_c[LAST];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
